adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_pkg.sv | 19 +
 rtl/adc_spi_reader_sclk_tick_gen.sv | 38 +++
 rtl/adc_spi_reader.sv | 143 ++++++++++++++
 tb/tb_adc_spi_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI reader: FSM state encoding and default
// frame geometry.
package adc_spi_pkg;

   // Frame sequencing states of the reader
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Default number of data bits per frame (MSB first)
   localparam int DEFAULT_WIDTH   = 16;
   // Default number of clk_i cycles per SCLK half-period
   localparam int DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/adc_spi_reader_sclk_tick_gen.sv
// Half-period tick generator: tick_o is high on the last cycle of every
// ClkDiv-cycle window. clear_i restarts the window so that every FSM state
// begins with a full half-period.
module sclk_tick_gen #(
   parameter int ClkDiv = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic tick_o
);

   // A divide-by-one still needs a one-bit counter; it simply never leaves 0.
   localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

   logic [DivW-1:0] div_q;
   logic [DivW-1:0] div_d;

   assign tick_o = (div_q == DivW'(ClkDiv - 1));

   // Next divider value: restart on clear, wrap at the end of a half-period
   always_comb begin
      div_d = div_q + DivW'(1);
      if (clear_i || tick_o) begin
         div_d = '0;
      end
   end

   // Divider register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 reader for a serial ADC. One start_i request in IDLE produces
// one frame: chip-select assertion, a setup half-period, Width SCLK pulses
// sampling miso_i on each rising edge, a hold half-period, then a one-cycle
// DONE state that publishes the word with a valid_o pulse.
module adc_spi_reader
   import adc_spi_pkg::*;
#(
   parameter int Width  = DEFAULT_WIDTH,
   parameter int ClkDiv = DEFAULT_CLK_DIV
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             miso_i,
   output logic             sclk_o,
   output logic             cs_n_o,
   output logic [Width-1:0] data_o,
   output logic             valid_o,
   output logic             busy_o
);

   localparam int CntW = $clog2(Width + 1);

   state_e            state_q,   state_d;
   logic              sclk_q,    sclk_d;
   logic              cs_n_q,    cs_n_d;
   logic              valid_q,   valid_d;
   logic              busy_q,    busy_d;
   logic [Width-1:0]  data_q,    data_d;
   logic [Width-1:0]  shift_q,   shift_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;

   logic tick;
   logic state_change;

   // The divider restarts whenever the FSM moves, so each state's duration
   // is counted from its own entry edge.
   assign state_change = (state_d != state_q);

   sclk_tick_gen #(
      .ClkDiv (ClkDiv)
   ) u_tick_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (state_change),
      .tick_o  (tick)
   );

   // Next-state and registered-output logic for the frame sequencer
   always_comb begin
      state_d   = state_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      valid_d   = 1'b0;
      data_d    = data_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            sclk_d    = 1'b0;
            cs_n_d    = 1'b1;
            bit_cnt_d = '0;
            if (start_i) begin
               state_d = ST_SETUP;
               cs_n_d  = 1'b0;
               shift_d = '0;
            end
         end

         ST_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  // Rising SCLK: capture the bit the ADC has been presenting
                  shift_d   = {shift_q[Width-2:0], miso_i};
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end else if (bit_cnt_q == CntW'(Width)) begin
                  // Falling SCLK after the last captured bit ends the burst
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (tick) begin
               state_d = ST_DONE;
               cs_n_d  = 1'b1;
               valid_d = 1'b1;
               data_d  = shift_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         data_q    <= data_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign sclk_o  = sclk_q;
   assign cs_n_o  = cs_n_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: a 16-bit/div-2 instance and a 12-bit/div-1
// instance, each fed by a behavioural ADC that presents the MSB when chip
// select falls and the next bit after every SCLK falling edge.
module tb_adc_spi_reader;

   logic        clk;
   logic        rst;
   logic        start_a, miso_a, sclk_a, cs_n_a, valid_a, busy_a;
   logic [15:0] data_a;
   logic        start_b, miso_b, sclk_b, cs_n_b, valid_b, busy_b;
   logic [11:0] data_b;

   int checks;
   int failures;

   adc_spi_reader #(.Width(16), .ClkDiv(2)) dut_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start_a),
      .miso_i  (miso_a),
      .sclk_o  (sclk_a),
      .cs_n_o  (cs_n_a),
      .data_o  (data_a),
      .valid_o (valid_a),
      .busy_o  (busy_a)
   );

   adc_spi_reader #(.Width(12), .ClkDiv(1)) dut_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start_b),
      .miso_i  (miso_b),
      .sclk_o  (sclk_b),
      .cs_n_o  (cs_n_b),
      .data_o  (data_b),
      .valid_o (valid_b),
      .busy_o  (busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ADCs
   logic [15:0] word_a;
   logic [11:0] word_b;
   int          idx_a, idx_b;

   initial begin
      miso_a = 1'b0;
      miso_b = 1'b0;
      idx_a  = 0;
      idx_b  = 0;
   end

   always @(negedge cs_n_a) begin
      idx_a  = 15;
      miso_a = word_a[idx_a];
   end
   always @(negedge sclk_a) begin
      if (!cs_n_a && idx_a > 0) begin
         idx_a  = idx_a - 1;
         miso_a = word_a[idx_a];
      end
   end
   always @(negedge cs_n_b) begin
      idx_b  = 11;
      miso_b = word_b[idx_b];
   end
   always @(negedge sclk_b) begin
      if (!cs_n_b && idx_b > 0) begin
         idx_b  = idx_b - 1;
         miso_b = word_b[idx_b];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic g_sclk(input int w);
      return (w != 0) ? sclk_b : sclk_a;
   endfunction
   function automatic logic g_cs(input int w);
      return (w != 0) ? cs_n_b : cs_n_a;
   endfunction
   function automatic logic g_valid(input int w);
      return (w != 0) ? valid_b : valid_a;
   endfunction
   function automatic logic g_busy(input int w);
      return (w != 0) ? busy_b : busy_a;
   endfunction
   function automatic logic [15:0] g_data(input int w);
      return (w != 0) ? {4'h0, data_b} : data_a;
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w != 0) start_b = v;
      else        start_a = v;
   endtask

   // One complete frame on DUT w; the reference expectation is the word the
   // ADC drives, a latency of (2*Width+2)*ClkDiv edges and Width SCLK pulses.
   task automatic frame(input int w, input logic [15:0] word, input bit inject);
      int          wd, cd, cyc, rises, extra_valid, idle_len;
      logic        prev;
      bit          cs_low, cs_idle;
      logic [15:0] exp;
      wd  = (w != 0) ? 12 : 16;
      cd  = (w != 0) ? 1 : 2;
      exp = (w != 0) ? (word & 16'h0FFF) : word;
      if (w != 0) word_b = word[11:0];
      else        word_a = word;
      cyc = 0; rises = 0; cs_low = 1'b1; cs_idle = 1'b1; extra_valid = 0;

      @(negedge clk);
      set_start(w, 1'b1);
      @(posedge clk); #1;
      set_start(w, 1'b0);
      check("accept_cs_n", 32'(g_cs(w)), 32'd0);
      check("accept_busy", 32'(g_busy(w)), 32'd1);
      prev = g_sclk(w);
      while (!g_valid(w) && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         if (g_sclk(w) && !prev) rises++;
         prev = g_sclk(w);
         if (!g_valid(w) && g_cs(w)) cs_low = 1'b0;
         set_start(w, inject && (cyc == 5 || cyc == 20 || cyc == 40));
      end
      set_start(w, 1'b0);
      check("valid_latency", 32'(cyc), 32'((2 * wd + 2) * cd));
      check("frame_data", 32'(g_data(w)), 32'(exp));
      check("sclk_rises", 32'(rises), 32'(wd));
      check("cs_low_in_frame", 32'(cs_low), 32'd1);
      check("done_cs_n", 32'(g_cs(w)), 32'd1);
      $display("frame dut=%0d word=%h data=%h latency=%0d rises=%0d", w, exp, g_data(w), cyc, rises);

      // Request during DONE must be dropped, not queued
      if (inject) set_start(w, 1'b1);
      @(posedge clk); #1;
      set_start(w, 1'b0);
      check("valid_one_cycle", 32'(g_valid(w)), 32'd0);
      check("idle_busy", 32'(g_busy(w)), 32'd0);

      idle_len = inject ? 80 : 3;
      for (int i = 0; i < idle_len; i++) begin
         @(posedge clk); #1;
         if (g_valid(w)) extra_valid++;
         if (!g_cs(w)) cs_idle = 1'b0;
      end
      check("no_extra_valid", 32'(extra_valid), 32'd0);
      check("cs_n_idle", 32'(cs_idle), 32'd1);
   endtask

   initial begin
      int t, nv, run, rises, n, vcount;
      int vt[3];
      logic prev;
      bit cs_hi;
      logic [15:0] w16;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start_a  = 1'b0;
      start_b  = 1'b0;
      word_a   = '0;
      word_b   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk_a",  32'(sclk_a),  32'd0);
      check("rst_cs_n_a",  32'(cs_n_a),  32'd1);
      check("rst_valid_a", 32'(valid_a), 32'd0);
      check("rst_busy_a",  32'(busy_a),  32'd0);
      check("rst_data_a",  32'(data_a),  32'd0);
      check("rst_cs_n_b",  32'(cs_n_b),  32'd1);
      check("rst_data_b",  32'(data_b),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed words, constant-high and constant-low MISO
      frame(0, 16'hA5C3, 1'b0);
      frame(0, 16'hFFFF, 1'b0);
      frame(0, 16'h0000, 1'b0);

      // Stray start requests inside and at the end of a frame
      frame(0, 16'($urandom), 1'b1);

      // Randomized words
      for (int k = 0; k < 3; k++) frame(0, 16'($urandom), 1'b0);

      // start_i held high: back-to-back frames
      w16    = 16'($urandom);
      word_a = w16;
      t = 0; nv = 0; run = 0;
      vt[0] = 0; vt[1] = 0; vt[2] = 0;
      @(negedge clk);
      start_a = 1'b1;
      while (nv < 3 && t < 400) begin
         @(posedge clk); #1;
         t++;
         if (cs_n_a) begin
            run++;
         end else begin
            if (run > 0 && nv > 0) check("b2b_cs_n_gap", 32'(run), 32'd2);
            run = 0;
         end
         if (valid_a) begin
            vt[nv] = t;
            nv++;
            check("b2b_data", 32'(data_a), 32'(w16));
         end
      end
      start_a = 1'b0;
      check("b2b_valid_count", 32'(nv), 32'd3);
      check("b2b_period_1", 32'(vt[1] - vt[0]), 32'd70);
      check("b2b_period_2", 32'(vt[2] - vt[1]), 32'd70);
      $display("back-to-back valid at %0d %0d %0d", vt[0], vt[1], vt[2]);
      repeat (3) @(negedge clk);

      // Reset after the 8th SCLK rising edge
      word_a = 16'($urandom);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      rises = 0; n = 0; prev = sclk_a;
      while (rises < 8 && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (sclk_a && !prev) rises++;
         prev = sclk_a;
      end
      check("abort_rises", 32'(rises), 32'd8);
      rst = 1'b1;
      #1;
      check("abort_sclk",  32'(sclk_a),  32'd0);
      check("abort_cs_n",  32'(cs_n_a),  32'd1);
      check("abort_busy",  32'(busy_a),  32'd0);
      check("abort_valid", 32'(valid_a), 32'd0);
      check("abort_data",  32'(data_a),  32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      vcount = 0; cs_hi = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (valid_a) vcount++;
         if (!cs_n_a) cs_hi = 1'b0;
      end
      check("abort_no_valid", 32'(vcount), 32'd0);
      check("abort_cs_idle",  32'(cs_hi),  32'd1);
      check("abort_data_held", 32'(data_a), 32'd0);
      $display("reset abort after %0d rises", rises);
      frame(0, 16'h1234, 1'b0);

      // Narrow, undivided instance
      frame(1, 16'h0ABC, 1'b0);
      frame(1, 16'h0FFF, 1'b0);
      for (int k = 0; k < 3; k++) frame(1, 16'($urandom), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
